// File: rtl/uart_bus_responder.sv
// uart_bus_responder: device side of the CPU serial-port handshake.
//   The CPU writes bytes with wrn and reads received bytes with rdn. The block
//   reports status on tbre/tsre/data_ready/rx_overrun and frames serial data on txd/rxd.
// Latency: a write is accepted on the cycle wrn falls. The THR loads on the next edge,
//   and START appears on txd one edge after that. A received byte shows on
//   bus_dout/data_ready one edge after its STOP sample.
// Backpressure: while tbre=0, writes are dropped silently. While data_ready=1, new RX bytes
//   are dropped and the sticky rx_overrun flag is set instead.
// Option: define UART_PARITY_EN to add an even-parity bit to both directions.
//   The default build is plain 8N1.
// Ports:
//   CLK, RST                 clock; synchronous active-high reset
//   wrn, rdn, bus_din        CPU write/read strobes (active-low) and write data
//   bus_dout, bus_doe        read data (RBR) and its bus drive-enable
//   tbre, tsre               transmit holding register empty / shifter idle
//   data_ready, rx_overrun   unread byte present / byte lost while full (sticky)
//   rxd, txd                 serial line (rxd asynchronous, txd idles high)
module uart_bus_responder #(
  parameter int CLKS_PER_BIT = 72
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wrn,
  input  logic       rdn,
  input  logic [7:0] bus_din,
  output logic [7:0] bus_dout,
  output logic       bus_doe,
  output logic       tbre,
  output logic       tsre,
  output logic       data_ready,
  output logic       rx_overrun,
  input  logic       rxd,
  output logic       txd
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
`else
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

  // ---------------- CPU strobes ----------------
  logic r_wrn_q;
  logic r_rdn_q;
  logic w_wr_acc;
  logic w_rd_end;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wrn_q <= 1'b1;
      r_rdn_q <= 1'b1;
    end else begin
      r_wrn_q <= wrn;
      r_rdn_q <= rdn;
    end
  end

  assign w_wr_acc = r_wrn_q & ~wrn;   // falling edge of wrn
  assign w_rd_end = ~r_rdn_q & rdn;   // rising edge of rdn

  // ---------------- transmit holding register ----------------
  logic [7:0] r_thr;
  logic       r_tbre;
  logic       w_tx_load;

  // A load and an accepted write are mutually exclusive: a load needs tbre=0,
  // and a write is only taken with tbre=1. So a write on the load edge is dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_thr  <= 8'h00;
      r_tbre <= 1'b1;
    end else if (w_tx_load) begin
      r_tbre <= 1'b1;
    end else if (w_wr_acc && r_tbre) begin
      r_thr  <= bus_din;
      r_tbre <= 1'b0;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t     r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_tx_cnt,   w_tx_cnt_nxt;
  logic [2:0]    r_tx_bit,   w_tx_bit_nxt;
  logic [7:0]    r_tx_shift, w_tx_shift_nxt;
  logic          r_txd,      w_txd_nxt;
  logic          r_tsre,     w_tsre_nxt;
  logic          w_tx_last;
`ifdef UART_PARITY_EN
  logic          r_tx_par,   w_tx_par_nxt;
`endif

  assign w_tx_last = (r_tx_cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
      r_txd      <= 1'b1;
      r_tsre     <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_txd      <= w_txd_nxt;
      r_tsre     <= w_tsre_nxt;
`ifdef UART_PARITY_EN
      r_tx_par   <= w_tx_par_nxt;
`endif
    end
  end

  // txd is registered. Each state sets the level for the next bit on the
  // edge that ends the current bit.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_txd_nxt      = r_txd;
    w_tsre_nxt     = r_tsre;
    w_tx_load      = 1'b0;
`ifdef UART_PARITY_EN
    w_tx_par_nxt   = r_tx_par;
`endif
    if (r_tx_state != TX_IDLE) begin
      w_tx_cnt_nxt = w_tx_last ? '0 : r_tx_cnt + 1'b1;
    end
    case (r_tx_state)
      TX_IDLE: begin
        if (!r_tbre) w_tx_load = 1'b1;
      end
      TX_START: begin
        if (w_tx_last) begin
          w_tx_state_nxt = TX_DATA;
          w_txd_nxt      = r_tx_shift[0];
        end
      end
      TX_DATA: begin
        if (w_tx_last) begin
          w_tx_bit_nxt = r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            w_tx_state_nxt = TX_PAR;
            w_txd_nxt      = r_tx_par;
`else
            w_tx_state_nxt = TX_STOP;
            w_txd_nxt      = 1'b1;
`endif
          end else begin
            w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
            w_txd_nxt      = r_tx_shift[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PAR: begin
        if (w_tx_last) begin
          w_tx_state_nxt = TX_STOP;
          w_txd_nxt      = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (w_tx_last) begin
          if (!r_tbre) begin
            w_tx_load = 1'b1;       // back-to-back frame, no idle gap
          end else begin
            w_tx_state_nxt = TX_IDLE;
            w_tsre_nxt     = 1'b1;
          end
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
    if (w_tx_load) begin
      w_tx_state_nxt = TX_START;
      w_tx_cnt_nxt   = '0;
      w_tx_bit_nxt   = 3'd0;
      w_tx_shift_nxt = r_thr;
      w_txd_nxt      = 1'b0;
      w_tsre_nxt     = 1'b0;
`ifdef UART_PARITY_EN
      w_tx_par_nxt   = ^r_thr;
`endif
    end
  end

  // ---------------- RX synchroniser ----------------
  logic r_rx_s1;
  logic r_rxs;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_s1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_rx_s1 <= rxd;
      r_rxs   <= r_rx_s1;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_t     r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_rx_cnt,   w_rx_cnt_nxt;
  logic [2:0]    r_rx_bit,   w_rx_bit_nxt;
  logic [7:0]    r_rx_shift, w_rx_shift_nxt;
  logic          w_rx_ok;    // a complete, well-formed byte is in r_rx_shift
  logic          w_rx_last;
`ifdef UART_PARITY_EN
  logic          r_rx_par,   w_rx_par_nxt;
`endif

  assign w_rx_last = (r_rx_cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
`ifdef UART_PARITY_EN
      r_rx_par   <= 1'b0;
`endif
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
`ifdef UART_PARITY_EN
      r_rx_par   <= w_rx_par_nxt;
`endif
    end
  end

  // After the mid-start sample, the counter restarts. Every later sample then
  // lands mid-bit, one full bit period apart.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_ok        = 1'b0;
`ifdef UART_PARITY_EN
    w_rx_par_nxt   = r_rx_par;
`endif
    case (r_rx_state)
      RX_IDLE: begin
        if (!r_rxs) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == CNT_MID) begin
          w_rx_cnt_nxt = '0;
          if (r_rxs) begin
            w_rx_state_nxt = RX_IDLE;   // false start (glitch)
          end else begin
            w_rx_state_nxt = RX_DATA;
            w_rx_bit_nxt   = 3'd0;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (w_rx_last) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rxs, r_rx_shift[7:1]};
          w_rx_bit_nxt   = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            w_rx_state_nxt = RX_PAR;
`else
            w_rx_state_nxt = RX_STOP;
`endif
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      RX_PAR: begin
        if (w_rx_last) begin
          w_rx_cnt_nxt   = '0;
          w_rx_par_nxt   = r_rxs;
          w_rx_state_nxt = RX_STOP;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
`endif
      RX_STOP: begin
        if (w_rx_last) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = RX_IDLE;   // leave at mid-stop for resync margin
`ifdef UART_PARITY_EN
          w_rx_ok = r_rxs & (r_rx_par == ^r_rx_shift);
`else
          w_rx_ok = r_rxs;
`endif
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------- receive buffer / status ----------------
  logic [7:0] r_rbr;
  logic       r_data_ready;
  logic       r_rx_overrun;

  // If a read ends on the same edge that a byte arrives, the buffer counts as
  // free. The new byte is stored and no overrun is flagged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rbr        <= 8'h00;
      r_data_ready <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (w_rd_end) begin
        r_data_ready <= 1'b0;
        r_rx_overrun <= 1'b0;
      end
      if (w_rx_ok) begin
        if (!r_data_ready || w_rd_end) begin
          r_rbr        <= r_rx_shift;
          r_data_ready <= 1'b1;
        end else begin
          r_rx_overrun <= 1'b1;
        end
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus_dout   = r_rbr;
  assign bus_doe    = ~rdn & ~RST;
  assign tbre       = r_tbre;
  assign tsre       = r_tsre;
  assign txd        = r_txd;
  assign data_ready = r_data_ready;
  assign rx_overrun = r_rx_overrun;

endmodule

// File: tb/tb_uart_bus_responder.sv
`timescale 1ns/1ps
module tb_uart_bus_responder;
  localparam int CPB = 8;
`ifdef UART_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       wrn;
  logic       rdn;
  logic [7:0] bus_din;
  logic [7:0] bus_dout;
  logic       bus_doe;
  logic       tbre;
  logic       tsre;
  logic       data_ready;
  logic       rx_overrun;
  logic       rxd;
  logic       txd;

  uart_bus_responder #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .wrn(wrn), .rdn(rdn), .bus_din(bus_din),
    .bus_dout(bus_dout), .bus_doe(bus_doe), .tbre(tbre), .tsre(tsre),
    .data_ready(data_ready), .rx_overrun(rx_overrun), .rxd(rxd), .txd(txd)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  // Reference model of the receive side: buffer contents and status flags.
  logic [7:0] m_rbr;
  logic       m_dr;
  logic       m_ov;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Serial line level for bit position i of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9 && FBITS == 11) return ^b;
    return 1'b1;
  endfunction

  task automatic do_write(input logic [7:0] b);
    bus_din = b;
    wrn = 1'b0;
    tick();
    wrn = 1'b1;
  endtask

  task automatic do_read();
    rdn = 1'b0;
    #1;
    chk("rd_doe_on", bus_doe, 1);
    chk("rd_dout", bus_dout, m_rbr);
    tick();
    rdn = 1'b1;
    #1;
    chk("rd_doe_off", bus_doe, 0);
    tick();
    m_dr = 1'b0;
    m_ov = 1'b0;
    chk("rd_dr_clr", data_ready, m_dr);
    chk("rd_ov_clr", rx_overrun, m_ov);
  endtask

  // Checks nf consecutive frames, cycle by cycle, starting at the first START cycle.
  task automatic check_tx(input logic [7:0] b0, input logic [7:0] b1, input int nf);
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < FBITS; i++) begin
        for (int c = 0; c < CPB; c++) begin
          chk($sformatf("txd f%0d bit%0d c%0d", f, i, c), txd, frame_bit((f == 0) ? b0 : b1, i));
          if (c == 0) chk($sformatf("tsre_busy f%0d bit%0d", f, i), tsre, 0);
          tick();
        end
      end
    end
    chk("tsre_done", tsre, 1);
    chk("txd_idle", txd, 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_v, input logic par_flip);
    logic v;
    for (int i = 0; i < FBITS; i++) begin
      v = frame_bit(b, i);
      if (i == FBITS - 1) v = stop_v;
      if (FBITS == 11 && i == 9) v = v ^ par_flip;
      rxd = v;
      repeat (CPB) tick();
    end
    rxd = 1'b1;
    repeat (24) tick();
    if (stop_v && !(FBITS == 11 && par_flip)) begin
      if (!m_dr) begin
        m_rbr = b;
        m_dr  = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end
  endtask

  task automatic glitch(input int len);
    rxd = 1'b0;
    repeat (len) tick();
    rxd = 1'b1;
    repeat (24) tick();
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_dr"}, data_ready, m_dr);
    chk({tag, "_ov"}, rx_overrun, m_ov);
    chk({tag, "_dout"}, bus_dout, m_rbr);
  endtask

  initial begin
    logic [7:0] b;
    int op;
    RST = 1'b1; wrn = 1'b1; rdn = 1'b0; rxd = 1'b1; bus_din = 8'h00;
    m_rbr = 8'h00; m_dr = 1'b0; m_ov = 1'b0;

    // Reset with rdn held low: the bus must stay undriven.
    repeat (3) tick();
    chk("rst_txd", txd, 1);
    chk("rst_tbre", tbre, 1);
    chk("rst_tsre", tsre, 1);
    chk("rst_dr", data_ready, 0);
    chk("rst_ov", rx_overrun, 0);
    chk("rst_doe", bus_doe, 0);
    chk("rst_dout", bus_dout, 0);
    RST = 1'b0; rdn = 1'b1;
    repeat (3) tick();

    // Single frame 0xA5.
    do_write(8'hA5);
    chk("a5_tbre_busy", tbre, 0);
    chk("a5_txd_pre", txd, 1);
    tick();
    chk("a5_tbre_free", tbre, 1);
    check_tx(8'hA5, 8'h00, 1);
    repeat (4) tick();

    // Back-to-back frames; the third write lands while tbre=0 and is dropped.
    do_write(8'h3C);
    tick();
    fork
      check_tx(8'h3C, 8'hC3, 2);
      begin
        chk("b2b_tbre_free", tbre, 1);
        do_write(8'hC3);
        chk("b2b_tbre_full", tbre, 0);
        repeat (3) tick();
        do_write(8'h77);
        chk("b2b_drop_tbre", tbre, 0);
      end
    join
    for (int k = 0; k < 2 * FBITS; k++) begin
      chk("b2b_no_third", txd, 1);
      repeat (CPB) tick();
    end
    chk("b2b_tbre_end", tbre, 1);

    // Random single frames with random idle gaps.
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 5)) tick();
      do_write(b);
      tick();
      check_tx(b, 8'h00, 1);
    end

    // Receive 0x5A and read it.
    send_rx(8'h5A, 1'b1, 1'b0);
    check_rx("rx5a");
    do_read();

    // Overrun: the second byte is lost and the first is kept.
    send_rx(8'h11, 1'b1, 1'b0);
    send_rx(8'h22, 1'b1, 1'b0);
    check_rx("ovr");
    send_rx(8'h44, 1'b0, 1'b0);
    check_rx("ovr_frame_err");
    glitch(3);
    check_rx("ovr_glitch");
    do_read();

    // Framing error and glitch with an empty buffer leave data_ready low.
    send_rx(8'h66, 1'b0, 1'b0);
    check_rx("ferr_empty");
    glitch(3);
    check_rx("glitch_empty");

    // Random receive-side traffic against the model.
    for (int k = 0; k < 14; k++) begin
      op = $urandom_range(0, 4);
      case (op)
        0, 1: send_rx(8'($urandom), 1'b1, 1'($urandom_range(0, 3) == 0));
        2: send_rx(8'($urandom), 1'b0, 1'b0);
        3: glitch($urandom_range(1, 3));
        default: do_read();
      endcase
      check_rx($sformatf("rnd%0d", k));
    end

    // Reset in the middle of a frame, during DATA bit 0 of 0x96 (txd low).
    send_rx(8'hA1, 1'b1, 1'b0);
    do_write(8'h96);
    tick();
    repeat (CPB + 2) tick();
    chk("mid_txd_low", txd, 0);
    RST = 1'b1;
    tick();
    m_rbr = 8'h00; m_dr = 1'b0; m_ov = 1'b0;
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_tbre", tbre, 1);
    chk("mid_rst_tsre", tsre, 1);
    check_rx("mid_rst");
    RST = 1'b0;
    repeat (2) tick();
    do_write(8'hFF);
    tick();
    check_tx(8'hFF, 8'h00, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
